// File: rtl/store_buffer_pkg.sv
// Shared types and helpers for the store buffer: default geometry, the
// queued-entry record, and the word-granular address compare key.
package store_buffer_pkg;

    localparam int SB_DEPTH  = 4;
    localparam int SB_ADDR_W = 32;
    localparam int SB_DATA_W = 32;

    // One queued store. valid marks slots between the read and write pointers.
    typedef struct packed {
        logic                 valid;
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
    } sb_entry_t;

    // Byte address -> word key; the two byte-offset bits never take part in a match.
    function automatic logic [SB_ADDR_W-1:0] word_addr(input logic [SB_ADDR_W-1:0] addr);
        return addr >> 2;
    endfunction

endpackage

// File: rtl/store_buffer_fifo.sv
// Circular queue of posted stores. Exposes every slot so the top can search
// for the youngest store to a given word, plus head pointer and occupancy.
// Pushes into a full queue and pops from an empty one are ignored.
module store_buffer_fifo
    import store_buffer_pkg::*;
#(
    parameter int  DEPTH = SB_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 push,
    input  logic [SB_ADDR_W-1:0] push_addr,
    input  logic [SB_DATA_W-1:0] push_data,
    input  logic                 pop,
    output sb_entry_t            entries [DEPTH],
    output logic [PTR_W-1:0]     rd_ptr,
    output logic [CNT_W-1:0]     count,
    output logic                 full,
    output logic                 empty
);

    sb_entry_t        slots [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign entries = slots;

    // Slot storage, pointers (wrap naturally at DEPTH) and occupancy count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_pop) begin
                slots[rd_ptr].valid <= 1'b0;
                rd_ptr              <= rd_ptr + PTR_W'(1);
            end
            if (do_push) begin
                slots[wr_ptr] <= '{valid: 1'b1, addr: push_addr, data: push_data};
                wr_ptr        <= wr_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Write buffer between the CPU memory stage and a single-port data memory.
// Stores are posted into a small queue and written back in cycles the CPU
// leaves the port idle; loads take the port with priority.
// Build option STORE_BUFFER_FORWARD_EN: a load that hits a queued store is
// answered from the youngest matching entry in the same cycle. Without it,
// such a load stalls while the head drains until no queued entry matches,
// then reads memory.
//
// Port ownership: any accepted CPU access (load or store) owns the cycle, so
// the queue drains only when the CPU is idle, stalled, or being answered by
// forwarding. A stalled request is held by the CPU and is not accepted.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH  = SB_DEPTH,
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DATA_W = SB_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_MemRead,
    input  logic              cpu_MemWrite,
    input  logic [ADDR_W-1:0] cpu_endereco,
    input  logic [DATA_W-1:0] cpu_write_data,
    output logic [DATA_W-1:0] cpu_read_data,
    output logic              stall,
    input  logic              flush,
    output logic              empty,
    output logic              mem_MemRead,
    output logic              mem_MemWrite,
    output logic [ADDR_W-1:0] mem_endereco,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    sb_entry_t        entries [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_after;
    logic             fifo_full;
    logic             fifo_empty;

    logic             hit;
    logic [PTR_W-1:0] idx;
`ifdef STORE_BUFFER_FORWARD_EN
    logic [DATA_W-1:0] hit_data;
`endif
    logic             hit_stall;
    logic             load_acc;
    logic             store_acc;
    logic             load_port;
    logic             drain;
    logic             flushing;
    logic             flushing_next;

    store_buffer_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (store_acc),
        .push_addr (cpu_endereco),
        .push_data (cpu_write_data),
        .pop       (drain),
        .entries   (entries),
        .rd_ptr    (rd_ptr),
        .count     (count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Oldest-to-youngest scan so the last match found is the youngest store to the word.
    always_comb begin
        hit = 1'b0;
        idx = rd_ptr;
`ifdef STORE_BUFFER_FORWARD_EN
        hit_data = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if (entries[idx].valid &&
                word_addr(entries[idx].addr) == word_addr(cpu_endereco)) begin
                hit = 1'b1;
`ifdef STORE_BUFFER_FORWARD_EN
                hit_data = entries[idx].data;
`endif
            end
        end
    end

`ifdef STORE_BUFFER_FORWARD_EN
    assign hit_stall = 1'b0;
    assign load_port = load_acc & ~hit;
`else
    assign hit_stall = cpu_MemRead & hit;
    assign load_port = load_acc;
`endif

    // A full queue refuses a store even if the head would drain this cycle.
    // A pending flush request stalls from the cycle it is raised.
    assign stall     = ~reset & ((cpu_MemWrite & fifo_full) | flushing |
                                 (flush & ~fifo_empty) | hit_stall);
    assign load_acc  = ~reset & cpu_MemRead & ~stall;
    // A store presented together with a load is dropped; the load is served.
    assign store_acc = ~reset & cpu_MemWrite & ~cpu_MemRead & ~stall;
    assign drain     = ~reset & ~fifo_empty & ~load_port & ~store_acc;
    assign empty     = fifo_empty;

    // Memory-port mux: load address, else head-of-queue write, else all zero.
    always_comb begin
        mem_MemRead    = load_port;
        mem_MemWrite   = drain;
        mem_endereco   = '0;
        mem_write_data = '0;
        cpu_read_data  = '0;
        if (load_port) begin
            mem_endereco  = cpu_endereco;
            cpu_read_data = mem_read_data;
        end else if (drain) begin
            mem_endereco   = entries[rd_ptr].addr;
            mem_write_data = entries[rd_ptr].data;
        end
`ifdef STORE_BUFFER_FORWARD_EN
        if (load_acc && hit) begin
            cpu_read_data = hit_data;
        end
`endif
    end

    assign count_after   = count - CNT_W'(drain) + CNT_W'(store_acc);
    assign flushing_next = (flushing | (flush & ~fifo_empty)) & (count_after != '0);

    // Flush flag: set by a flush request with work queued, cleared once the queue empties.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            flushing <= 1'b0;
        end else begin
            flushing <= flushing_next;
        end
    end

    // Load and store in the same cycle is a CPU protocol violation.
    assert property (@(posedge clock) disable iff (reset) !(cpu_MemRead && cpu_MemWrite));

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed vectors with literal expectations plus a
// queue-based reference model checked on every falling clock edge.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        init_mem;
  logic        cpu_MemRead, cpu_MemWrite, flush;
  logic [31:0] cpu_endereco, cpu_write_data, cpu_read_data;
  logic        stall, empty, mem_MemRead, mem_MemWrite;
  logic [31:0] mem_endereco, mem_write_data, mem_read_data;
  logic [31:0] dmem [64];
  int          n_vec = 0;
  int          n_err = 0;

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .cpu_MemRead    (cpu_MemRead),
    .cpu_MemWrite   (cpu_MemWrite),
    .cpu_endereco   (cpu_endereco),
    .cpu_write_data (cpu_write_data),
    .cpu_read_data  (cpu_read_data),
    .stall          (stall),
    .flush          (flush),
    .empty          (empty),
    .mem_MemRead    (mem_MemRead),
    .mem_MemWrite   (mem_MemWrite),
    .mem_endereco   (mem_endereco),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  // clock / memory
  always #5 clock = ~clock;

  assign mem_read_data = dmem[mem_endereco[7:2]];

  always @(posedge clock) begin
    if (init_mem) begin
      for (int i = 0; i < 64; i++) dmem[i] <= 32'hD000_0000 + i;
    end else if (mem_MemWrite) begin
      dmem[mem_endereco[7:2]] <= mem_write_data;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: queue of posted stores and a memory image
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } st_t;

  st_t         mq[$];
  logic [31:0] exp_mem [64];
  logic        m_flushing;

  initial begin : model
    int          cnt;
    logic        hit;
    logic [31:0] hit_data;
    logic        e_stall, e_lacc, e_sacc, e_lport, e_drain;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic        p_drain, p_store, p_fl;
    logic [31:0] p_a, p_d;
    for (int i = 0; i < 64; i++) exp_mem[i] = 32'hD000_0000 + i;
    m_flushing = 1'b0;
    forever begin
      @(negedge clock);
      p_drain = 1'b0; p_store = 1'b0; p_fl = 1'b0; p_a = '0; p_d = '0;
      if (reset) begin
        mq.delete();
        m_flushing = 1'b0;
        chk1("m_rst_empty", empty, 1'b1);
        chk1("m_rst_stall", stall, 1'b0);
        chk1("m_rst_mrd", mem_MemRead, 1'b0);
        chk1("m_rst_mwr", mem_MemWrite, 1'b0);
        chk("m_rst_addr", mem_endereco, 32'h0);
        chk("m_rst_rdata", cpu_read_data, 32'h0);
      end else begin
        cnt = mq.size();
        hit = 1'b0;
        hit_data = '0;
        foreach (mq[i]) begin
          if (mq[i].addr[31:2] == cpu_endereco[31:2]) begin
            hit = 1'b1;
            hit_data = mq[i].data;
          end
        end
        e_stall = (cpu_MemWrite && cnt == DEPTH) || m_flushing || (flush && cnt > 0);
`ifndef STORE_BUFFER_FORWARD_EN
        if (cpu_MemRead && hit) e_stall = 1'b1;
`endif
        e_lacc = cpu_MemRead && !e_stall;
        e_sacc = cpu_MemWrite && !cpu_MemRead && !e_stall;
`ifdef STORE_BUFFER_FORWARD_EN
        e_lport = e_lacc && !hit;
`else
        e_lport = e_lacc;
`endif
        e_drain = (cnt > 0) && !e_lport && !e_sacc;
        e_addr  = e_lport ? cpu_endereco : (e_drain ? mq[0].addr : 32'h0);
        e_wdata = (!e_lport && e_drain) ? mq[0].data : 32'h0;
        e_rdata = e_lport ? exp_mem[cpu_endereco[7:2]] : 32'h0;
`ifdef STORE_BUFFER_FORWARD_EN
        if (e_lacc && hit) e_rdata = hit_data;
`endif
        chk1("m_stall", stall, e_stall);
        chk1("m_empty", empty, cnt == 0);
        chk1("m_mrd", mem_MemRead, e_lport);
        chk1("m_mwr", mem_MemWrite, e_drain);
        chk("m_maddr", mem_endereco, e_addr);
        chk("m_wdata", mem_write_data, e_wdata);
        chk("m_rdata", cpu_read_data, e_rdata);
        p_drain = e_drain;
        p_store = e_sacc;
        p_fl    = flush && cnt > 0;
        p_a     = cpu_endereco;
        p_d     = cpu_write_data;
      end
      @(posedge clock);
      if (!reset) begin
        if (p_drain) begin
          exp_mem[mq[0].addr[7:2]] = mq[0].data;
          void'(mq.pop_front());
        end
        if (p_store) mq.push_back('{addr: p_a, data: p_d});
        m_flushing = (m_flushing || p_fl) && (mq.size() != 0);
      end
    end
  end

  // driver tasks
  task automatic apply(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic fl);
    @(posedge clock);
    #1;
    cpu_MemRead    = rd;
    cpu_MemWrite   = wr;
    cpu_endereco   = a;
    cpu_write_data = d;
    flush          = fl;
    @(negedge clock);
  endtask

  task automatic idle();
    apply(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    apply(1'b0, 1'b1, a, d, 1'b0);
  endtask

  task automatic load(input logic [31:0] a);
    apply(1'b1, 1'b0, a, 32'h0, 1'b0);
  endtask

  initial begin : watchdog
    #200000;
    n_err++;
    $display("FAIL watchdog: simulation did not finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int waits;
    reset = 1'b1; init_mem = 1'b1;
    cpu_MemRead = 1'b0; cpu_MemWrite = 1'b0; flush = 1'b0;
    cpu_endereco = '0; cpu_write_data = '0;
    @(posedge clock); #1; init_mem = 1'b0;
    @(negedge clock);
    chk1("rst_empty", empty, 1'b1);
    chk1("rst_stall", stall, 1'b0);
    chk1("rst_mwr", mem_MemWrite, 1'b0);
    @(posedge clock); #1; reset = 1'b0;

    // single store drains in the following idle cycle
    store(32'h10, 32'hAAAA_0001);
    chk1("t2_stall", stall, 1'b0);
    chk1("t2_no_write_yet", mem_MemWrite, 1'b0);
    idle();
    chk1("t2_drain_we", mem_MemWrite, 1'b1);
    chk("t2_drain_addr", mem_endereco, 32'h10);
    chk("t2_drain_data", mem_write_data, 32'hAAAA_0001);
    idle();
    chk1("t2_empty", empty, 1'b1);
    chk1("t2_no_extra_write", mem_MemWrite, 1'b0);

    // load miss with three queued takes the port, no drain
    store(32'h30, 32'h1);
    store(32'h34, 32'h2);
    store(32'h38, 32'h3);
    load(32'h24);
    chk1("t5_mrd", mem_MemRead, 1'b1);
    chk1("t5_no_drain", mem_MemWrite, 1'b0);
    chk("t5_addr", mem_endereco, 32'h24);
    chk("t5_rdata", cpu_read_data, 32'hD000_0009);
    chk1("t5_stall", stall, 1'b0);

    // flush with three queued: three stalled cycles, FIFO-order writes
    apply(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    chk1("t6_stall0", stall, 1'b1);
    chk("t6_addr0", mem_endereco, 32'h30);
    chk("t6_data0", mem_write_data, 32'h1);
    store(32'h50, 32'h5555);
    chk1("t6_stall1", stall, 1'b1);
    chk("t6_addr1", mem_endereco, 32'h34);
    store(32'h50, 32'h5555);
    chk1("t6_stall2", stall, 1'b1);
    chk("t6_addr2", mem_endereco, 32'h38);
    chk("t6_data2", mem_write_data, 32'h3);
    store(32'h50, 32'h5555);
    chk1("t6_released", stall, 1'b0);
    chk1("t6_empty", empty, 1'b1);
    idle();
    chk("t6_held_store_addr", mem_endereco, 32'h50);

    // two stores to one word, then a load of that word
    store(32'h20, 32'h5);
    store(32'h20, 32'h7);
    load(32'h20);
    chk1("t4_first_drain", mem_MemWrite, 1'b1);
    chk("t4_first_data", mem_write_data, 32'h5);
`ifdef STORE_BUFFER_FORWARD_EN
    chk1("t4_fwd_stall", stall, 1'b0);
    chk("t4_fwd_rdata", cpu_read_data, 32'h7);
    idle();
    chk("t4_second_data", mem_write_data, 32'h7);
`else
    waits = 0;
    while (stall && waits < 8) begin
      waits++;
      load(32'h20);
    end
    chk("t4_stall_cycles", waits, 2);
    chk1("t4_mrd", mem_MemRead, 1'b1);
    chk("t4_mem_rdata", cpu_read_data, 32'h7);
`endif
    load(32'h20);
    chk("t4_reload", cpu_read_data, 32'h7);

    // fill with loads in between, fifth store stalls until a drain
    store(32'h0, 32'h100);
    load(32'h40);
    chk("t3_load_rdata", cpu_read_data, 32'hD000_0010);
    store(32'h4, 32'h101);
    load(32'h40);
    store(32'h8, 32'h102);
    load(32'h40);
    store(32'hC, 32'h103);
    store(32'h10, 32'h104);
    chk1("t3_full_stall", stall, 1'b1);
    chk1("t3_full_drain", mem_MemWrite, 1'b1);
    chk("t3_full_addr", mem_endereco, 32'h0);
    waits = 0;
    while (stall && waits < 8) begin
      waits++;
      store(32'h10, 32'h104);
    end
    chk("t3_stall_cycles", waits, 1);
    waits = 0;
    do begin
      idle();
      waits++;
    end while (!empty && waits < 10);
    chk1("t3_drained", empty, 1'b1);

    // reset in the middle of draining
    store(32'h60, 32'hA1);
    store(32'h64, 32'hA2);
    store(32'h68, 32'hA3);
    idle();
    chk("t1_pre_addr", mem_endereco, 32'h60);
    @(posedge clock); #1; reset = 1'b1;
    @(negedge clock);
    chk1("t1_empty", empty, 1'b1);
    chk1("t1_stall", stall, 1'b0);
    chk1("t1_mwr", mem_MemWrite, 1'b0);
    @(posedge clock); #1; reset = 1'b0;
    @(negedge clock);
    chk1("t1_after_mwr", mem_MemWrite, 1'b0);
    idle();
    idle();
    chk1("t1_no_write", mem_MemWrite, 1'b0);
    load(32'h64);
    chk("t1_lost_store", cpu_read_data, 32'hD000_0019);
    load(32'h60);
    chk("t1_kept_write", cpu_read_data, 32'hA1);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
